// File: rtl/logic_cmd_parser.sv
// UART command-frame parser: hunts for 00 00 00 01, collects a 5-byte payload, validates it and
// commits the capture configuration; cfg/err pulses appear on the 2nd edge after the last byte; no backpressure.
module logic_cmd_parser #(
  parameter int unsigned P_TIMEOUT = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [15:0] o_send_len,
  output logic [7:0]  o_channel,
  output logic [2:0]  o_tri_model,
  output logic [3:0]  o_frq_sel,
  output logic        o_pulse,
  output logic        o_send_model,
  output logic        o_cfg_valid,
  output logic        o_frame_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_zero_cnt;
  logic [2:0]  r_idx;
  logic [31:0] r_to_cnt;
  logic [7:0]  r_pl [5];

  logic [15:0] r_send_len;
  logic [7:0]  r_channel;
  logic [2:0]  r_tri_model;
  logic [3:0]  r_frq_sel;
  logic        r_pulse;
  logic        r_send_model;
  logic        r_cfg_valid;
  logic        r_frame_err;

  logic        w_frame_ok;
  logic        w_to_hit;
  logic        w_hunt_byte;

  // The 33-bit compare keeps the saturated all-ones counter from wrapping to zero.
  assign w_to_hit    = (r_state == S_PAYLOAD) && !i_rx_valid &&
                       (({1'b0, r_to_cnt} + 33'd1) >= 33'(P_TIMEOUT));
  assign w_frame_ok  = !r_pl[3][7] && (r_pl[4][7:2] == 6'd0) && ({r_pl[0], r_pl[1]} != 16'd0);
  assign w_hunt_byte = i_rx_valid && ((r_state == S_HUNT) || (r_state == S_CHECK));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HUNT: begin
        if (i_rx_valid && (i_rx_data == 8'h01) && (r_zero_cnt == 2'd3)) begin
          w_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (i_rx_valid && (r_idx == 3'd4)) begin
          w_next = S_CHECK;
        end else if (w_to_hit) begin
          w_next = S_HUNT;
        end
      end
      S_CHECK: w_next = S_HUNT;
      default: w_next = S_HUNT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_HUNT;
      r_zero_cnt <= 2'd0;
      r_idx      <= 3'd0;
      r_to_cnt   <= 32'd0;
      for (int i = 0; i < 5; i++) begin
        r_pl[i] <= 8'd0;
      end
    end else begin
      r_state <= w_next;

      if (w_hunt_byte) begin
        if (i_rx_data == 8'h00) begin
          r_zero_cnt <= (r_zero_cnt == 2'd3) ? 2'd3 : r_zero_cnt + 2'd1;
        end else begin
          r_zero_cnt <= 2'd0;
        end
      end

      if ((r_state == S_PAYLOAD) && i_rx_valid) begin
        for (int i = 0; i < 5; i++) begin
          if (r_idx == 3'(i)) begin
            r_pl[i] <= i_rx_data;
          end
        end
        r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
      end else if (w_to_hit) begin
        r_idx <= 3'd0;
      end

      if ((r_state != S_PAYLOAD) || i_rx_valid || w_to_hit) begin
        r_to_cnt <= 32'd0;
      end else if (r_to_cnt != 32'hFFFF_FFFF) begin
        r_to_cnt <= r_to_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_send_len   <= 16'd0;
      r_channel    <= 8'd0;
      r_tri_model  <= 3'd0;
      r_frq_sel    <= 4'd0;
      r_pulse      <= 1'b0;
      r_send_model <= 1'b0;
      r_cfg_valid  <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_cfg_valid <= (r_state == S_CHECK) && w_frame_ok;
      r_frame_err <= ((r_state == S_CHECK) && !w_frame_ok) || w_to_hit;
      if ((r_state == S_CHECK) && w_frame_ok) begin
        r_send_len   <= {r_pl[0], r_pl[1]};
        r_channel    <= r_pl[2];
        r_tri_model  <= r_pl[3][6:4];
        r_frq_sel    <= r_pl[3][3:0];
        r_pulse      <= r_pl[4][1];
        r_send_model <= r_pl[4][0];
      end
    end
  end

  assign o_send_len   = r_send_len;
  assign o_channel    = r_channel;
  assign o_tri_model  = r_tri_model;
  assign o_frq_sel    = r_frq_sel;
  assign o_pulse      = r_pulse;
  assign o_send_model = r_send_model;
  assign o_cfg_valid  = r_cfg_valid;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = (r_state != S_HUNT);

endmodule
